// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: command opcodes, TAP state encoding, TMS sequence lengths.
// Used by jtag_master and by TAP-side logic that decodes the same state space.
package jtag_pkg;

    typedef enum logic [1:0] {
        OP_RESET   = 2'd0,
        OP_SCAN_IR = 2'd1,
        OP_SCAN_DR = 2'd2,
        OP_RSVD    = 2'd3
    } cmd_op_e;

    typedef enum logic [3:0] {
        TAP_RESET    = 4'd0,
        TAP_IDLE     = 4'd1,
        TAP_SEL_DR   = 4'd2,
        TAP_CAP_DR   = 4'd3,
        TAP_SHIFT_DR = 4'd4,
        TAP_EXIT1_DR = 4'd5,
        TAP_PAUSE_DR = 4'd6,
        TAP_EXIT2_DR = 4'd7,
        TAP_UPD_DR   = 4'd8,
        TAP_SEL_IR   = 4'd9,
        TAP_CAP_IR   = 4'd10,
        TAP_SHIFT_IR = 4'd11,
        TAP_EXIT1_IR = 4'd12,
        TAP_PAUSE_IR = 4'd13,
        TAP_EXIT2_IR = 4'd14,
        TAP_UPD_IR   = 4'd15
    } tap_state_e;

    typedef enum logic [2:0] {
        ST_RST_SEQ = 3'd0,
        ST_IDLE    = 3'd1,
        ST_NAV     = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_EXIT    = 3'd4
    } mst_state_e;

    localparam logic [2:0] IR_PREFIX_LEN = 3'd4;
    localparam logic [2:0] DR_PREFIX_LEN = 3'd3;
    localparam logic [2:0] SUFFIX_LEN    = 3'd2;
    localparam logic [2:0] RESET_LEN     = 3'd6;

    function automatic logic [2:0] prefix_len(input cmd_op_e op);
        return (op == OP_SCAN_IR) ? IR_PREFIX_LEN : DR_PREFIX_LEN;
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: 2*CLK_DIV clk cycles per period, low phase first, with
// one-cycle strobes on the clk edges where TCK rises and falls.
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tck,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] RISE_AT = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FALL_AT = CW'(2 * CLK_DIV - 1);

    logic [CW-1:0] cnt_r;

    assign rise_tick = en && (cnt_r == RISE_AT);
    assign fall_tick = en && (cnt_r == FALL_AT);

    // Phase counter and TCK level; both parked at zero while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            tck   <= 1'b0;
        end else if (!en || fall_tick) begin
            cnt_r <= '0;
            tck   <= 1'b0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
            tck   <= rise_tick ? 1'b1 : tck;
        end
    end

endmodule

// File: rtl/jtag_master.sv
// Host-side JTAG master: runs RESET / IR scan / DR scan commands, every one
// starting and ending in Run-Test/Idle. Optional TRST via JTAG_MASTER_TRST_EN.
module jtag_master #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [1:0]                 cmd_op_i,
    input  logic [$clog2(MAX_LEN)-1:0] cmd_len_i,
    input  logic [MAX_LEN-1:0]         cmd_data_i,
    output logic                       rsp_valid_o,
    output logic [MAX_LEN-1:0]         rsp_data_o,
    output logic                       tck_o,
    output logic                       tms_o,
    output logic                       tdi_o,
    input  logic                       tdo_i
`ifdef JTAG_MASTER_TRST_EN
    ,
    output logic                       trst_no
`endif
);
    import jtag_pkg::*;

    localparam int LW = $clog2(MAX_LEN);

    mst_state_e         state_r, state_nx;
    cmd_op_e            op_r, op_nx;
    logic [2:0]         seq_r, seq_nx;
    logic [LW-1:0]      bit_r, bit_nx, len_r, len_nx;
    logic [MAX_LEN-1:0] sr_r, sr_nx, cap_r;
    logic               auto_r;
    logic               accept_s, done_s, tms_nx, tdi_nx;
    logic               fall_s, rise_s;

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
        .clk       (clk_i),
        .rst       (rst_i),
        .en        (state_r != ST_IDLE),
        .tck       (tck_o),
        .fall_tick (fall_s),
        .rise_tick (rise_s)
    );

    // Next state: the registered state always describes the TCK period in progress.
    always_comb begin
        accept_s = cmd_valid_i && cmd_ready_o;
        op_nx    = accept_s ? cmd_op_e'(cmd_op_i) : op_r;
        len_nx   = accept_s ? cmd_len_i : len_r;
        sr_nx    = accept_s ? cmd_data_i : sr_r;
        state_nx = state_r;
        seq_nx   = seq_r;
        bit_nx   = bit_r;
        done_s   = 1'b0;
        case (state_r)
            ST_RST_SEQ: begin
                if (fall_s && (seq_r == RESET_LEN - 3'd1)) begin
                    state_nx = ST_IDLE;
                    done_s   = 1'b1;
                end else begin
                    seq_nx = fall_s ? seq_r + 3'd1 : seq_r;
                end
            end
            ST_IDLE: begin
                if (accept_s) begin
                    seq_nx = 3'd0;
                    bit_nx = '0;
                    case (op_nx)
                        OP_RESET:               state_nx = ST_RST_SEQ;
                        OP_SCAN_IR, OP_SCAN_DR: state_nx = ST_NAV;
                        default:                done_s   = 1'b1;
                    endcase
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_NAV: begin
                if (fall_s && (seq_r == prefix_len(op_r) - 3'd1)) begin
                    state_nx = ST_SHIFT;
                    bit_nx   = '0;
                end else begin
                    seq_nx = fall_s ? seq_r + 3'd1 : seq_r;
                end
            end
            ST_SHIFT: begin
                if (fall_s && (bit_r == len_r)) begin
                    state_nx = ST_EXIT;
                    seq_nx   = 3'd0;
                end else if (fall_s) begin
                    bit_nx = bit_r + LW'(1);
                    sr_nx  = sr_r >> 1;
                end else begin
                    bit_nx = bit_r;
                end
            end
            ST_EXIT: begin
                if (fall_s && (seq_r == SUFFIX_LEN - 3'd1)) begin
                    state_nx = ST_IDLE;
                    done_s   = 1'b1;
                end else begin
                    seq_nx = fall_s ? seq_r + 3'd1 : seq_r;
                end
            end
            default: state_nx = ST_RST_SEQ;
        endcase
    end

    // TMS/TDI for the period about to run, derived from the next-state view.
    always_comb begin
        tms_nx = 1'b0;
        tdi_nx = 1'b0;
        case (state_nx)
            ST_RST_SEQ: tms_nx = (seq_nx != RESET_LEN - 3'd1);
            ST_NAV:     tms_nx = (op_nx == OP_SCAN_IR) ? (seq_nx < 3'd2) : (seq_nx == 3'd0);
            ST_SHIFT: begin
                tms_nx = (bit_nx == len_nx);
                tdi_nx = sr_nx[0];
            end
            ST_EXIT:    tms_nx = (seq_nx == 3'd0);
            default:    tms_nx = 1'b0;
        endcase
    end

    // FSM state, counters and shift register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_RST_SEQ;
            op_r    <= OP_RESET;
            seq_r   <= 3'd0;
            bit_r   <= '0;
            len_r   <= '0;
            sr_r    <= '0;
        end else begin
            state_r <= state_nx;
            op_r    <= op_nx;
            seq_r   <= seq_nx;
            bit_r   <= bit_nx;
            len_r   <= len_nx;
            sr_r    <= sr_nx;
        end
    end

    // TDO capture, pin outputs and responses; the power-up sequence never responds.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_r       <= '0;
            auto_r      <= 1'b1;
            tms_o       <= 1'b1;
            tdi_o       <= 1'b0;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
        end else begin
            if (accept_s) begin
                cap_r  <= '0;
                auto_r <= 1'b0;
            end else if (rise_s && (state_r == ST_SHIFT)) begin
                cap_r[bit_r] <= tdo_i;
            end else begin
                cap_r <= cap_r;
            end
            tms_o       <= tms_nx;
            tdi_o       <= tdi_nx;
            cmd_ready_o <= (state_nx == ST_IDLE);
            rsp_valid_o <= done_s && (accept_s || !auto_r);
            rsp_data_o  <= (done_s && !accept_s && !auto_r) ? cap_r : rsp_data_o;
        end
    end

`ifdef JTAG_MASTER_TRST_EN
    // TRST covers the first TCK period of every reset sequence.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trst_no <= 1'b0;
        end else if (accept_s && (op_nx == OP_RESET)) begin
            trst_no <= 1'b0;
        end else if (fall_s) begin
            trst_no <= 1'b1;
        end else begin
            trst_no <= trst_no;
        end
    end
`endif

endmodule

// File: tb/tb_jtag_master.sv
// Scoreboard bench for jtag_master: expected TCK/TMS/TDI streams and responses
// are built from the command rules at issue time; a monitor checks each response.
module tb_jtag_master;

    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 32;
    localparam int HP      = 2 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [4:0]  cmd_len = 5'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        tck, tms, tdi, tdo;
`ifdef JTAG_MASTER_TRST_EN
    logic        trst_n;
`endif

    jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_len_i   (cmd_len),
        .cmd_data_i  (cmd_data),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .tck_o       (tck),
        .tms_o       (tms),
        .tdi_o       (tdi),
        .tdo_i       (tdo)
`ifdef JTAG_MASTER_TRST_EN
        ,
        .trst_no     (trst_n)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;
        int          acc;
        int          base;
        int          t;
        logic [63:0] tms;
        logic [63:0] tdi;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          tck_total = 0;
    logic        tms_log [0:8191];
    logic        tdi_log [0:8191];
    logic [63:0] tdo_pat = 64'd0;
    int          tdo_base = 0;
    int          tidx;
    logic [31:0] last_rsp = 32'd0;

    // TAP stand-in: drives a preselected TDO bit for each TCK of the current command.
    always_comb begin
        tidx = tck_total - tdo_base;
        tdo  = (tidx >= 0 && tidx < 64) ? tdo_pat[tidx[5:0]] : 1'b0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge tck) begin
        if (tck_total < 8192) begin
            tms_log[tck_total] <= tms;
            tdi_log[tck_total] <= tdi;
        end
        tck_total <= tck_total + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse pops one expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got a pulse expected none (cycle %0d)", cyc);
            end else begin
                logic [63:0] atms, atdi;
                mon_e = sb.pop_front();
                atms = 64'd0;
                atdi = 64'd0;
                for (int i = 0; i < mon_e.t && i < 64; i++) begin
                    atms[i] = tms_log[mon_e.base + i];
                    atdi[i] = tdi_log[mon_e.base + i];
                end
                chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
                chk("latency", 64'(cyc - mon_e.acc), 64'(1 + mon_e.t * HP));
                chk("tck_count", 64'(tck_total - mon_e.base), 64'(mon_e.t));
                chk("tms_seq", atms, mon_e.tms);
                chk("tdi_seq", atdi, mon_e.tdi);
                chk("ready_at_rsp", 64'(cmd_ready), 64'd1);
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input int op, input int len, input logic [31:0] data,
                        input logic [63:0] pat, input bit hold, output int acc);
        int   g = 0;
        int   n, pre;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_op    = op[1:0];
        cmd_len   = len[4:0];
        cmd_data  = data;
        while (!cmd_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        acc = cyc;
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: ready low after %0d cycles", g);
            cmd_valid = 1'b0;
            return;
        end
        n      = len + 1;
        e.op   = op;
        e.acc  = cyc;
        e.base = tck_total;
        e.t    = 0;
        e.tms  = 64'd0;
        e.tdi  = 64'd0;
        e.data = last_rsp;
        case (op)
            0: begin
                e.t    = 6;
                e.tms  = 64'h1F;
                e.data = 32'd0;
            end
            1, 2: begin
                pre    = (op == 1) ? 4 : 3;
                e.t    = pre + n + 2;
                e.tms  = (op == 1) ? 64'h3 : 64'h1;
                e.data = 32'd0;
                for (int i = 0; i < n; i++) begin
                    e.tdi[pre + i] = data[i];
                    e.data[i]      = pat[pre + i];
                end
                e.tms[pre + n - 1] = 1'b1;
                e.tms[pre + n]     = 1'b1;
            end
            default: e.t = 0;
        endcase
        last_rsp = e.data;
        sb.push_back(e);
        tdo_pat  = pat;
        tdo_base = tck_total;
        @(negedge clk);
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd_op    = 2'($urandom);
            cmd_len   = 5'($urandom);
            cmd_data  = $urandom;
        end
    endtask

    // Called at a negedge: asserts reset at once, then checks the automatic sequence.
    task automatic do_reset();
        int n = 0;
        int base;
        logic [63:0] atms;
        rst = 1'b1;
        #1;
        chk("rst_tck", 64'(tck), 64'd0);
        chk("rst_tms", 64'(tms), 64'd1);
        chk("rst_tdi", 64'(tdi), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
`ifdef JTAG_MASTER_TRST_EN
        chk("rst_trst", 64'(trst_n), 64'd0);
`endif
        sb.delete();
        last_rsp = 32'd0;
        repeat (3) @(negedge clk);
        base = tck_total;
        rst  = 1'b0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
`ifdef JTAG_MASTER_TRST_EN
            if (n == HP - 1) chk("trst_low_seq", 64'(trst_n), 64'd0);
            if (n == HP) chk("trst_high_seq", 64'(trst_n), 64'd1);
`endif
        end
        chk("rstseq_ready_cycle", 64'(n), 64'(6 * HP));
        chk("rstseq_tck_count", 64'(tck_total - base), 64'd6);
        atms = 64'd0;
        for (int i = 0; i < 6; i++) atms[i] = tms_log[base + i];
        chk("rstseq_tms", atms, 64'h1F);
    endtask

    initial begin
        int          acc1, acc2, g;
        logic [31:0] d;
        repeat (2) @(negedge clk);
        do_reset();

        send(1, 4, 32'h1, 64'h10, 1'b0, acc1);
        @(negedge clk);
        d = 32'hA5A5_0F0F;
        send(2, 31, d, {29'd0, d[30:0], 1'b0, 3'd0}, 1'b0, acc1);

        send(2, 7, $urandom, {$urandom, $urandom}, 1'b1, acc1);
        send(1, 4, $urandom, {$urandom, $urandom}, 1'b0, acc2);
        chk("b2b_accept_cycle", 64'(acc2), 64'(acc1 + 1 + 13 * HP));

        send(3, 9, $urandom, 64'd0, 1'b0, acc1);

        send(0, 0, 32'd0, 64'd0, 1'b0, acc1);
`ifdef JTAG_MASTER_TRST_EN
        chk("trst_op_start", 64'(trst_n), 64'd0);
        repeat (HP - 1) @(negedge clk);
        chk("trst_op_low", 64'(trst_n), 64'd0);
        @(negedge clk);
        chk("trst_op_high", 64'(trst_n), 64'd1);
`endif

        send(2, 31, $urandom, {$urandom, $urandom}, 1'b0, acc1);
        g = 0;
        while (tck_total < tdo_base + 14 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        chk("midscan_reached", 64'(tck_total >= tdo_base + 14), 64'd1);
        do_reset();
        send(2, 31, $urandom, {$urandom, $urandom}, 1'b0, acc1);

        for (int k = 0; k < 40; k++) begin
            send($urandom_range(0, 3), $urandom_range(0, 31), $urandom,
                 {$urandom, $urandom}, (k < 39) ? 1'($urandom_range(0, 1)) : 1'b0, acc1);
            if (!cmd_valid) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        g = 0;
        while (sb.size() > 0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
